// File: rtl/wb_bus_master_if.sv
// Wishbone B4 classic bus bundle between one CPU-port master and the bus fabric.
// Signal names keep the master-side _i/_o sense so they match the port list of the master.
interface wb_bus_master_if;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    modport master (
        input  wb_data_i, wb_ack_i,
        output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output wb_data_i, wb_ack_i,
        input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/wb_bus_master.sv
// Wishbone B4 classic master for one CPU pipeline port; holds the stage via stallreq_o
// while a bus cycle is outstanding and honours the controller's stall vector and flush.
module wb_bus_master #(
    parameter int STALL_IDX = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    wb_bus_master_if.master wb
);
    typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, data_reg, rd_buf_reg, tmo_cnt_reg;
    logic        we_reg, stb_reg, cyc_reg, bus_err_reg;
    logic [3:0]  sel_reg;

    logic accept, ack_hit, flush_hit, tmo_hit, frozen;

    // Termination priority inside BUSY: ack, then flush, then watchdog.
    assign frozen    = stall_i[STALL_IDX];
    assign accept    = (state_reg == IDLE) && cpu_ce_i && !flush_i;
    assign ack_hit   = (state_reg == BUSY) && wb.wb_ack_i;
    assign flush_hit = (state_reg == BUSY) && !wb.wb_ack_i && flush_i;
    assign tmo_hit   = (state_reg == BUSY) && !wb.wb_ack_i && !flush_i
                       && (TIMEOUT > 0) && (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = BUSY;
            end
            BUSY: begin
                if (ack_hit)                  state_next = frozen ? WAIT_STALL : IDLE;
                else if (flush_hit || tmo_hit) state_next = IDLE;
            end
            WAIT_STALL: begin
                if (flush_i || !frozen) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;
        case (state_reg)
            IDLE: stallreq_o = accept;
            BUSY: begin
                stallreq_o = !(ack_hit || flush_hit || tmo_hit);
                if (ack_hit && !we_reg) cpu_data_o = wb.wb_data_i;
            end
            WAIT_STALL: cpu_data_o = rd_buf_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg    <= 32'd0;
            data_reg    <= 32'd0;
            sel_reg     <= 4'd0;
            we_reg      <= 1'b0;
            stb_reg     <= 1'b0;
            cyc_reg     <= 1'b0;
            rd_buf_reg  <= 32'd0;
            tmo_cnt_reg <= 32'd0;
            bus_err_reg <= 1'b0;
        end else begin
            bus_err_reg <= tmo_hit;
            if (accept) begin
                addr_reg    <= cpu_addr_i;
                data_reg    <= cpu_data_i;
                sel_reg     <= cpu_sel_i;
                we_reg      <= cpu_we_i;
                stb_reg     <= 1'b1;
                cyc_reg     <= 1'b1;
                tmo_cnt_reg <= 32'd0;
            end else if (ack_hit || flush_hit || tmo_hit) begin
                addr_reg <= 32'd0;
                data_reg <= 32'd0;
                sel_reg  <= 4'd0;
                we_reg   <= 1'b0;
                stb_reg  <= 1'b0;
                cyc_reg  <= 1'b0;
                if (ack_hit && !we_reg) rd_buf_reg <= wb.wb_data_i;
                if (flush_hit)          rd_buf_reg <= 32'd0;
            end else if (state_reg == BUSY) begin
                // Saturate so a disabled watchdog never sees the count wrap.
                if (tmo_cnt_reg != '1) tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
            end else if (state_reg == WAIT_STALL && flush_i) begin
                rd_buf_reg <= 32'd0;
            end
        end
    end

    assign wb.wb_addr_o = addr_reg;
    assign wb.wb_data_o = data_reg;
    assign wb.wb_we_o   = we_reg;
    assign wb.wb_sel_o  = sel_reg;
    assign wb.wb_stb_o  = stb_reg;
    assign wb.wb_cyc_o  = cyc_reg;
    assign bus_err_o    = bus_err_reg;
endmodule

// File: tb/tb_wb_bus_master.sv
// Directed bench for wb_bus_master as a MEM port (stall bit 3) with an 8-cycle watchdog.
module tb_wb_bus_master;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush, ce, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] cpu_data;
    logic        stallreq, bus_err;
    int          tests_run = 0;
    int          tests_failed = 0;

    localparam logic [5:0] FRZ = 6'b001000;

    wb_bus_master_if bus ();

    wb_bus_master #(.STALL_IDX(3), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .flush_i    (flush),
        .cpu_ce_i   (ce),
        .cpu_addr_i (addr),
        .cpu_data_i (wdata),
        .cpu_we_i   (we),
        .cpu_sel_i  (sel),
        .cpu_data_o (cpu_data),
        .stallreq_o (stallreq),
        .bus_err_o  (bus_err),
        .wb         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        ce = 1'b1; addr = a; wdata = d; we = w; sel = s;
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; ce = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0;
        bus.wb_ack_i = 1'b0; bus.wb_data_i = '0;
        tick(); tick();
        #1;
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_addr", bus.wb_addr_o, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_buserr", bus_err, 0);
        rst = 1'b0;

        // T1: read, acked in the third BUSY cycle
        tick(); req(32'h40, 32'h0, 1'b0, 4'hF); #1;
        chk("t1_idle_stallreq", stallreq, 1);
        chk("t1_idle_stb", bus.wb_stb_o, 0);
        tick(); ce = 1'b0; #1;
        chk("t1_b1_stb", bus.wb_stb_o, 1);
        chk("t1_b1_cyc", bus.wb_cyc_o, 1);
        chk("t1_b1_addr", bus.wb_addr_o, 32'h40);
        chk("t1_b1_stallreq", stallreq, 1);
        tick(); #1;
        chk("t1_b2_stallreq", stallreq, 1);
        chk("t1_b2_data", cpu_data, 0);
        tick(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hDEADBEEF; #1;
        chk("t1_ack_stallreq", stallreq, 0);
        chk("t1_ack_data", cpu_data, 32'hDEADBEEF);
        tick(); bus.wb_ack_i = 1'b0; #1;
        chk("t1_end_stb", bus.wb_stb_o, 0);
        chk("t1_end_cyc", bus.wb_cyc_o, 0);
        chk("t1_end_addr", bus.wb_addr_o, 0);
        chk("t1_end_data", cpu_data, 0);

        // T2: write held stable until ack; ack under stall exposes rd_buf from T1
        tick(); req(32'h100, 32'h12345678, 1'b1, 4'b0011); #1;
        tick(); req(32'hFFFF_FFFF, 32'h0, 1'b0, 4'hF); ce = 1'b0; #1;
        chk("t2_b1_addr", bus.wb_addr_o, 32'h100);
        chk("t2_b1_wdata", bus.wb_data_o, 32'h12345678);
        chk("t2_b1_sel", bus.wb_sel_o, 4'b0011);
        chk("t2_b1_we", bus.wb_we_o, 1);
        tick(); #1;
        chk("t2_b2_addr", bus.wb_addr_o, 32'h100);
        chk("t2_b2_sel", bus.wb_sel_o, 4'b0011);
        tick(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hCAFEF00D; stall = FRZ; #1;
        chk("t2_ack_data", cpu_data, 0);
        chk("t2_ack_stallreq", stallreq, 0);
        tick(); bus.wb_ack_i = 1'b0; stall = '0; #1;
        chk("t2_ws_rdbuf", cpu_data, 32'hDEADBEEF);
        chk("t2_ws_stb", bus.wb_stb_o, 0);
        tick(); #1;
        chk("t2_idle_data", cpu_data, 0);

        // T3: read acked while frozen; held 3 WAIT_STALL cycles, no new request issued
        tick(); req(32'h200, 32'h0, 1'b0, 4'hF); #1;
        tick(); ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hA5A55A5A; stall = FRZ; #1;
        chk("t3_ack_data", cpu_data, 32'hA5A55A5A);
        tick(); bus.wb_ack_i = 1'b0; bus.wb_data_i = 32'h0; ce = 1'b1; #1;
        chk("t3_ws1_data", cpu_data, 32'hA5A55A5A);
        chk("t3_ws1_stallreq", stallreq, 0);
        chk("t3_ws1_stb", bus.wb_stb_o, 0);
        tick(); #1;
        chk("t3_ws2_data", cpu_data, 32'hA5A55A5A);
        chk("t3_ws2_stb", bus.wb_stb_o, 0);
        tick(); stall = '0; ce = 1'b0; #1;
        chk("t3_ws3_data", cpu_data, 32'hA5A55A5A);
        tick(); #1;
        chk("t3_idle_stb", bus.wb_stb_o, 0);
        chk("t3_idle_data", cpu_data, 0);

        // T4a: flush in BUSY without ack aborts; a late ack is ignored
        tick(); req(32'h300, 32'h0, 1'b0, 4'hF); #1;
        tick(); ce = 1'b0; #1;
        chk("t4_b1_stb", bus.wb_stb_o, 1);
        tick(); flush = 1'b1; #1;
        chk("t4_fl_stallreq", stallreq, 0);
        chk("t4_fl_data", cpu_data, 0);
        tick(); flush = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h11111111; #1;
        chk("t4_ab_stb", bus.wb_stb_o, 0);
        chk("t4_ab_cyc", bus.wb_cyc_o, 0);
        chk("t4_late_data", cpu_data, 0);
        chk("t4_late_stallreq", stallreq, 0);
        tick(); bus.wb_ack_i = 1'b0; #1;
        chk("t4_late_stb", bus.wb_stb_o, 0);

        // T4b: ack and flush together complete as an ack
        tick(); req(32'h304, 32'h0, 1'b0, 4'hF); #1;
        tick(); ce = 1'b0; bus.wb_ack_i = 1'b1; flush = 1'b1; bus.wb_data_i = 32'h87654321; stall = FRZ; #1;
        chk("t4_af_data", cpu_data, 32'h87654321);
        chk("t4_af_stallreq", stallreq, 0);
        tick(); bus.wb_ack_i = 1'b0; flush = 1'b0; #1;
        chk("t4_af_ws_data", cpu_data, 32'h87654321);
        // flush out of WAIT_STALL while still frozen; a new request then proves IDLE
        tick(); flush = 1'b1; #1;
        chk("t4_wsfl_data", cpu_data, 32'h87654321);

        // T5: watchdog abort after 8 BUSY cycles
        tick(); flush = 1'b0; req(32'h400, 32'h0, 1'b0, 4'hF); #1;
        chk("t4_wsfl_idle_stallreq", stallreq, 1);
        chk("t4_wsfl_idle_data", cpu_data, 0);
        tick(); ce = 1'b0; stall = '0; #1;
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("t5_b%0d_stallreq", i), stallreq, 1);
            chk($sformatf("t5_b%0d_stb", i), bus.wb_stb_o, 1);
            tick(); #1;
        end
        chk("t5_b8_stallreq", stallreq, 0);
        chk("t5_b8_buserr", bus_err, 0);
        chk("t5_b8_data", cpu_data, 0);
        tick(); #1;
        chk("t5_err_pulse", bus_err, 1);
        chk("t5_err_stb", bus.wb_stb_o, 0);
        chk("t5_err_cyc", bus.wb_cyc_o, 0);
        chk("t5_err_stallreq", stallreq, 0);
        tick(); #1;
        chk("t5_err_clear", bus_err, 0);

        // T6: reset mid-BUSY, then back-to-back requests with a one-cycle IDLE gap
        tick(); req(32'h500, 32'h55AA55AA, 1'b1, 4'hC); #1;
        tick(); ce = 1'b0; #1;
        chk("t6_b1_stb", bus.wb_stb_o, 1);
        rst = 1'b1;
        tick(); #1;
        chk("t6_rst_stb", bus.wb_stb_o, 0);
        chk("t6_rst_cyc", bus.wb_cyc_o, 0);
        chk("t6_rst_addr", bus.wb_addr_o, 0);
        chk("t6_rst_wdata", bus.wb_data_o, 0);
        chk("t6_rst_sel", bus.wb_sel_o, 0);
        chk("t6_rst_we", bus.wb_we_o, 0);
        rst = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h22222222; #1;
        chk("t6_postrst_data", cpu_data, 0);
        chk("t6_postrst_stallreq", stallreq, 0);
        tick(); bus.wb_ack_i = 1'b0; req(32'h600, 32'h0, 1'b0, 4'hF); #1;
        chk("t6_r1_stallreq", stallreq, 1);
        tick(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h0BADF00D; #1;
        chk("t6_r1_ack_data", cpu_data, 32'h0BADF00D);
        tick(); bus.wb_ack_i = 1'b0; addr = 32'h700; #1;
        chk("t6_gap_stb", bus.wb_stb_o, 0);
        chk("t6_gap_stallreq", stallreq, 1);
        tick(); ce = 1'b0; #1;
        chk("t6_r2_stb", bus.wb_stb_o, 1);
        chk("t6_r2_addr", bus.wb_addr_o, 32'h700);
        bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h33333333; #1;
        chk("t6_r2_ack_data", cpu_data, 32'h33333333);
        tick(); bus.wb_ack_i = 1'b0; #1;
        chk("t6_r2_end_stb", bus.wb_stb_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
